monitor_dbg_clock_gen: RTL and testbench
========================================

# monitor_dbg_clock_gen

Programmable debug-clock generator for the student CPU under monitor control. A Nios-side Avalon-MM slave stops the target clock, single-steps it, free-runs it at a programmed rate, or emits an N-cycle burst. Its `dbg_clk` output drives the target core and also feeds the 1-bit debug-clock input port, which reads the current level back into the monitor.

## Interface
Parameters:
- `DIV_WIDTH`, default 16: width of the half-period divisor register.
- `DIV_RESET`, default 16'd49999: divisor value after reset.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  Avalon word address.
- `chipselect`  in  1  Avalon select.
- `write_n`  in  1  Avalon write strobe, active low.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `dbg_clk`  out  1  generated debug clock, registered.
- `dbg_clk_rise`  out  1  one-`clk` pulse coincident with each `dbg_clk` rising edge.

## Operation
Register map:
- addr 0, CTRL:
  - bit0 RUN, R/W.
  - bit1 STEP, write-1 trigger, reads 0.
  - bit2 BURST_GO, write-1 trigger, reads 0.
  - bit4 BUSY, RO.
  - bit5 current `dbg_clk` level, RO.
- addr 1, DIV[DIV_WIDTH-1:0], R/W. Each phase lasts DIV+1 `clk` cycles.
- addr 2, BURST[15:0], R/W. Cycles remaining in the current burst.
- addr 3, CYCLES[31:0], RO count of `dbg_clk` rising edges. Any write clears it.
- Unused read bits return 0.

Write condition: `chipselect && !write_n`.

FSM states:
- IDLE: `dbg_clk`=0, BUSY=0.
- HIGH: `dbg_clk`=1.
- LOW: `dbg_clk`=0.

Phase counter `pcnt`, DIV_WIDTH bits:
- Loaded with DIV on entry to HIGH or LOW.
- Decrements every `clk`.
- The phase ends when `pcnt`=0.

Transitions:
- IDLE→HIGH on any of: RUN=1; a STEP write; a BURST_GO write with BURST≠0.
- HIGH→LOW at end of the phase.
- LOW→HIGH at end of the phase if RUN=1 or BURST≠0. Otherwise LOW→IDLE.
- BURST decrements on each HIGH entry taken for a burst. A burst of N produces exactly N pulses.

Edge cases:
- A STEP or BURST_GO write while BUSY=1 is ignored.
- Clearing RUN mid-cycle completes the current HIGH+LOW cycle. No runt pulses.
- A DIV write takes effect at the next phase load. The current phase is not stretched or truncated.
- RUN=1 with BURST≠0: free-run wins. BURST still decrements per pulse, down to 0.
- CYCLES wraps 0xFFFFFFFF→0.
- A CYCLES clear that coincides with a rising edge: the result is 0.
- DIV=0 gives `dbg_clk` = `clk`/2.

## Timing
- Reset values:
  - `readdata`=0, `dbg_clk`=0, `dbg_clk_rise`=0.
  - State IDLE.
  - RUN=0, DIV=`DIV_RESET`, BURST=0, CYCLES=0.
- `readdata` is registered every `clk` from `address`: one-cycle latency. It is not gated by a read strobe.
- Start latency: a trigger write sampled at edge k makes `dbg_clk`=1 and `dbg_clk_rise`=1 after edge k. `dbg_clk_rise` drops after edge k+1.
- HIGH lasts DIV+1 clks, then LOW lasts DIV+1 clks. Free-run period is 2·(DIV+1) clks.
- CYCLES increments on the same edge that asserts `dbg_clk_rise`.
- Reset mid-operation: everything returns to reset values asynchronously. `dbg_clk` falls immediately.

## Configuration
- `MONITOR_DBG_CLKGEN_BURST_EN` defined: the BURST register and the BURST_GO bit are implemented as described.
- Not defined:
  - addr 2 reads 0; writes are ignored.
  - BURST_GO is ignored.
  - LOW→HIGH depends on RUN only.
  - No burst counter logic is synthesised.

## Test plan
- Reset check: pulse `reset_n` low mid-run → `dbg_clk`=0 immediately; after release, DIV reads 49999 and CTRL, BURST and CYCLES read 0.
- Single step: DIV=2, write CTRL=0x2 → `dbg_clk` high for 3 clks, low for 3, then IDLE. CYCLES=1, BUSY back to 0. A second STEP written while busy is ignored, so CYCLES stays 1.
- Free run: DIV=0, RUN=1 for 20 clks, then RUN=0 → `dbg_clk` toggles every clk with period 2 and stops low after completing the cycle. CYCLES=10.
- Burst (macro on): DIV=1, BURST=5, write CTRL=0x4 → exactly 5 pulses of 2H/2L. BURST reads 0, BUSY=0 afterwards, CYCLES=5. With the macro off: 0 pulses, addr 2 reads 0.
- DIV change mid-run: RUN=1, DIV=3, change DIV to 1 during HIGH → the current HIGH still lasts 4 clks; subsequent phases last 2.
- Readback: write DIV=0x1234, read addr 1 → `readdata`=0x00001234 one clk after `address` is applied. Write addr 3 → CYCLES reads 0.

Source files
------------

// File: rtl/monitor_dbg_clock_gen.sv
// ---------------------------------------------------------------------------
// monitor_dbg_clock_gen
//
// Programmable debug-clock generator for the student CPU. The monitor
// controls it through an Avalon-MM slave. It can hold the target clock low,
// single-step it, free-run it at a programmed rate, or emit an N-cycle burst.
// dbg_clk drives the target core. It is also read back by the monitor through
// a 1-bit input port.
//
// Optional feature macro: MONITOR_DBG_CLKGEN_BURST_EN
//   defined   : the BURST register (addr 2) and CTRL.BURST_GO are implemented.
//   undefined : addr 2 reads 0 and ignores writes, and BURST_GO is ignored.
//
// Register map (word addresses):
//   0 CTRL   : [0] RUN rw, [1] STEP w1 trigger, [2] BURST_GO w1 trigger,
//              [4] BUSY ro, [5] dbg_clk level ro
//   1 DIV    : [DIV_WIDTH-1:0] half-period divisor; each phase is DIV+1 clks
//   2 BURST  : [15:0] pulses remaining in the current burst
//   3 CYCLES : [31:0] count of dbg_clk rising edges, ro, any write clears it
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   address      in   [1:0] Avalon word address
//   chipselect   in   Avalon select
//   write_n      in   Avalon write strobe, active low
//   writedata    in   [31:0] write data
//   readdata     out  [31:0] registered read data (address -> data in 1 clk)
//   dbg_clk      out  generated debug clock, registered
//   dbg_clk_rise out  one-clk pulse coincident with each dbg_clk rising edge
// ---------------------------------------------------------------------------
module monitor_dbg_clock_gen #(
  parameter int unsigned          DIV_WIDTH = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET = 16'd49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        dbg_clk,
  output logic        dbg_clk_rise
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [DIV_WIDTH-1:0]   r_pcnt;
  logic [DIV_WIDTH-1:0]   r_div;
  logic                   r_run;
  logic [31:0]            r_cycles;
  logic                   r_dbg_clk;
  logic                   r_rise;
  logic [31:0]            r_readdata;

  logic                   w_wr;
  logic                   w_wr_ctrl;
  logic                   w_wr_div;
  logic                   w_wr_cycles;
  logic                   w_run_eff;
  logic                   w_step;
  logic                   w_busy;
  logic                   w_phase_end;
  logic                   w_start;
  logic                   w_continue;
  logic                   w_enter_high;
  logic                   w_burst_nz;
  logic                   w_burst_start;
  logic [31:0]            w_rdata;
  logic                   w_unused;

  // Not every writedata bit maps to a register field. This collects the
  // unused bits.
  assign w_unused = &{1'b0, writedata};

  assign w_wr        = chipselect && !write_n;
  assign w_wr_ctrl   = w_wr && (address == 2'd0);
  assign w_wr_div    = w_wr && (address == 2'd1);
  assign w_wr_cycles = w_wr && (address == 2'd3);

  // RUN as it will be after this edge. A RUN write therefore starts the
  // clock with the same one-edge latency as a STEP. Clearing RUN on the edge
  // that ends a LOW phase stops the clock there, with no extra pulse.
  assign w_run_eff   = w_wr_ctrl ? writedata[0] : r_run;
  assign w_step      = w_wr_ctrl && writedata[1];
  assign w_busy      = (r_state != S_IDLE);
  assign w_phase_end = (r_pcnt == '0);

`ifdef MONITOR_DBG_CLKGEN_BURST_EN
  logic [15:0] r_burst;
  logic        w_wr_burst;
  logic        w_burst_go;
  logic        w_burst_dec;

  assign w_wr_burst    = w_wr && (address == 2'd2);
  assign w_burst_go    = w_wr_ctrl && writedata[2];
  assign w_burst_nz    = (r_burst != 16'd0);
  assign w_burst_start = w_burst_go && w_burst_nz;
  // Only HIGH entries that belong to a burst consume a count. A STEP that
  // happens to leave a loaded burst armed does not consume one. Free-run
  // pulses drain a loaded burst.
  assign w_burst_dec   = w_enter_high && w_burst_nz &&
                         ((r_state == S_LOW) || w_run_eff || w_burst_start);
`else
  assign w_burst_nz    = 1'b0;
  assign w_burst_start = 1'b0;
`endif

  assign w_start      = w_run_eff || w_step || w_burst_start;
  assign w_continue   = w_run_eff || w_burst_nz;
  assign w_enter_high = ((r_state == S_IDLE) && w_start) ||
                        ((r_state == S_LOW) && w_phase_end && w_continue);

  // Registers, phase counter and FSM. dbg_clk and dbg_clk_rise are set
  // together with the state, so they have no decode glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pcnt    <= '0;
      r_div     <= DIV_RESET;
      r_run     <= 1'b0;
      r_cycles  <= 32'd0;
      r_dbg_clk <= 1'b0;
      r_rise    <= 1'b0;
`ifdef MONITOR_DBG_CLKGEN_BURST_EN
      r_burst   <= 16'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout a clocked block, so every
      // right-hand side sees the pre-edge value whatever the statement order.
      r_rise <= 1'b0;

      if (w_wr_ctrl) r_run <= writedata[0];
      if (w_wr_div)  r_div <= writedata[DIV_WIDTH-1:0];

`ifdef MONITOR_DBG_CLKGEN_BURST_EN
      if (w_wr_burst)       r_burst <= writedata[15:0];
      else if (w_burst_dec) r_burst <= r_burst - 16'd1;
`endif

      // A clear on the same edge as a rising edge wins. The count reads 0.
      if (w_wr_cycles)       r_cycles <= 32'd0;
      else if (w_enter_high) r_cycles <= r_cycles + 32'd1;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_HIGH;
            r_pcnt    <= r_div;
            r_dbg_clk <= 1'b1;
            r_rise    <= 1'b1;
          end
        end
        S_HIGH: begin
          if (w_phase_end) begin
            r_state   <= S_LOW;
            r_pcnt    <= r_div;
            r_dbg_clk <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt - 1'b1;
          end
        end
        S_LOW: begin
          if (w_phase_end) begin
            if (w_continue) begin
              r_state   <= S_HIGH;
              r_pcnt    <= r_div;
              r_dbg_clk <= 1'b1;
              r_rise    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_pcnt <= r_pcnt - 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_dbg_clk <= 1'b0;
        end
      endcase
    end
  end

  // Read mux. The result is registered every clk, regardless of any read
  // strobe.
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // w_rdata unassigned (which would infer a latch).
    w_rdata = 32'd0;
    case (address)
      2'd0: w_rdata = {26'd0, r_dbg_clk, w_busy, 3'b000, r_run};
      2'd1: w_rdata[DIV_WIDTH-1:0] = r_div;
      2'd2: begin
`ifdef MONITOR_DBG_CLKGEN_BURST_EN
        w_rdata[15:0] = r_burst;
`endif
      end
      2'd3: w_rdata = r_cycles;
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= 32'd0;
    else          r_readdata <= w_rdata;
  end

  assign readdata     = r_readdata;
  assign dbg_clk      = r_dbg_clk;
  assign dbg_clk_rise = r_rise;

endmodule

// File: tb/tb_monitor_dbg_clock_gen.sv
// ---------------------------------------------------------------------------
// tb_monitor_dbg_clock_gen
//
// Self-checking bench for monitor_dbg_clock_gen.
//
// Register accesses come from a vector table. Each read pushes its expected
// value into a scoreboard queue. A monitor pops the entry and compares it on
// the clk after the address was applied.
//
// A second monitor records the length of every dbg_clk high run and low run,
// and counts rising edges. The hand-written sequences check these records for
// step, free-run, burst, DIV change and reset.
//
// Works with or without MONITOR_DBG_CLKGEN_BURST_EN.
// ---------------------------------------------------------------------------
module tb_monitor_dbg_clock_gen;

`ifdef MONITOR_DBG_CLKGEN_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif
  localparam logic [31:0] BURST_RD_EXP = BURST_ON ? 32'd7 : 32'd0;
  localparam int          BURST_PULSES = BURST_ON ? 5 : 0;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        dbg_clk;
  logic        dbg_clk_rise;

  monitor_dbg_clock_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .dbg_clk      (dbg_clk),
    .dbg_clk_rise (dbg_clk_rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read scoreboard: an expected value is due on the clk after the read.
  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp;
    int          due;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  always @(negedge clk) begin
    rd_exp_t e;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      check($sformatf("rd_addr%0d", e.addr), readdata, e.exp);
    end
  end

  // dbg_clk activity monitor
  bit mon_en    = 1'b0;
  bit prev_lvl  = 1'b0;
  int run_len   = 0;
  int rise_cnt  = 0;
  int hi_lens[$];
  int lo_lens[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (dbg_clk_rise || (dbg_clk && !prev_lvl))
        check("rise_pulse", {31'd0, dbg_clk_rise}, {31'd0, dbg_clk && !prev_lvl});
      if (dbg_clk_rise) rise_cnt++;
      if (dbg_clk == prev_lvl) begin
        run_len++;
      end else begin
        if (prev_lvl) hi_lens.push_back(run_len);
        else          lo_lens.push_back(run_len);
        run_len = 1;
      end
      prev_lvl = dbg_clk;
    end
  end

  // Bus tasks. Call them at a negedge. They return at the next negedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    sb_q.push_back('{a, exp, cyc + 1});
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[16];

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
      else            rd(vecs[i].addr, vecs[i].exp);
    end
  endtask

  initial begin
    int  rs, hs, ls;
    bit  found;

    // Register vectors: {wr, addr, wdata, expected read}
    vecs[0]  = '{0, 2'd0, 32'h0,        32'h0};          // CTRL reset
    vecs[1]  = '{0, 2'd1, 32'h0,        32'd49999};      // DIV reset
    vecs[2]  = '{0, 2'd2, 32'h0,        32'h0};          // BURST reset
    vecs[3]  = '{0, 2'd3, 32'h0,        32'h0};          // CYCLES reset
    vecs[4]  = '{1, 2'd1, 32'h1234,     32'h0};
    vecs[5]  = '{0, 2'd1, 32'h0,        32'h0000_1234};
    vecs[6]  = '{1, 2'd1, 32'hABCD5678, 32'h0};
    vecs[7]  = '{0, 2'd1, 32'h0,        32'h0000_5678};  // upper bits dropped
    vecs[8]  = '{1, 2'd2, 32'h7,        32'h0};
    vecs[9]  = '{0, 2'd2, 32'h0,        BURST_RD_EXP};
    vecs[10] = '{1, 2'd2, 32'h0,        32'h0};
    vecs[11] = '{0, 2'd2, 32'h0,        32'h0};
    vecs[12] = '{1, 2'd0, 32'hFFFF_FFF0, 32'h0};         // RO/unused bits only
    vecs[13] = '{0, 2'd0, 32'h0,        32'h0};
    vecs[14] = '{1, 2'd3, 32'hDEAD_BEEF, 32'h0};
    vecs[15] = '{0, 2'd3, 32'h0,        32'h0};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    check("rst_readdata", readdata, 32'h0);
    check("rst_dbg_clk", {31'd0, dbg_clk}, 32'd0);
    check("rst_rise", {31'd0, dbg_clk_rise}, 32'd0);
    run_vecs(0, 15);

    // Single step: DIV=2. The second STEP arrives while busy and is ignored.
    wr(2'd1, 32'd2);
    wr(2'd3, 32'd0);
    rs = rise_cnt;
    hs = hi_lens.size();
    wr(2'd0, 32'h2);
    check("step_start_clk", {31'd0, dbg_clk}, 32'd1);
    check("step_start_rise", {31'd0, dbg_clk_rise}, 32'd1);
    wr(2'd0, 32'h2);
    check("step_rise_drop", {31'd0, dbg_clk_rise}, 32'd0);
    check("step_still_high", {31'd0, dbg_clk}, 32'd1);
    repeat (4) @(negedge clk);
    rd(2'd0, 32'h10);                  // last LOW clk: BUSY, level 0
    rd(2'd0, 32'h00);                  // back to IDLE
    repeat (3) @(negedge clk);
    rd(2'd3, 32'd1);
    check("step_rises", 32'(rise_cnt - rs), 32'd1);
    check("step_hi_runs", 32'(hi_lens.size() - hs), 32'd1);
    if (hi_lens.size() > hs) check("step_hi_len", 32'(hi_lens[hs]), 32'd3);

    // Free run at DIV=0 for 20 clks.
    wr(2'd1, 32'd0);
    wr(2'd3, 32'd0);
    rs = rise_cnt;
    hs = hi_lens.size();
    ls = lo_lens.size();
    wr(2'd0, 32'h1);
    check("free_start_clk", {31'd0, dbg_clk}, 32'd1);
    repeat (19) @(negedge clk);
    wr(2'd0, 32'h0);
    check("free_stop_low", {31'd0, dbg_clk}, 32'd0);
    repeat (5) @(negedge clk);
    check("free_rises", 32'(rise_cnt - rs), 32'd10);
    check("free_hi_runs", 32'(hi_lens.size() - hs), 32'd10);
    check("free_lo_runs", 32'(lo_lens.size() - ls), 32'd10);
    for (int i = hs; i < hi_lens.size(); i++)
      check($sformatf("free_hi_len%0d", i - hs), 32'(hi_lens[i]), 32'd1);
    for (int i = ls + 1; i < lo_lens.size(); i++)
      check($sformatf("free_lo_len%0d", i - ls), 32'(lo_lens[i]), 32'd1);
    rd(2'd3, 32'd10);
    rd(2'd0, 32'h0);

    // Burst of 5 at DIV=1 (no pulses when the feature is compiled out)
    wr(2'd1, 32'd1);
    wr(2'd3, 32'd0);
    wr(2'd2, 32'd5);
    rs = rise_cnt;
    hs = hi_lens.size();
    ls = lo_lens.size();
    wr(2'd0, 32'h4);
    check("burst_start_clk", {31'd0, dbg_clk}, {31'd0, BURST_ON});
    repeat (25) @(negedge clk);
    check("burst_rises", 32'(rise_cnt - rs), 32'(BURST_PULSES));
    check("burst_hi_runs", 32'(hi_lens.size() - hs), 32'(BURST_PULSES));
    check("burst_lo_runs", 32'(lo_lens.size() - ls), 32'(BURST_PULSES));
    for (int i = hs; i < hi_lens.size(); i++)
      check($sformatf("burst_hi_len%0d", i - hs), 32'(hi_lens[i]), 32'd2);
    for (int i = ls + 1; i < lo_lens.size(); i++)
      check($sformatf("burst_lo_len%0d", i - ls), 32'(lo_lens[i]), 32'd2);
    rd(2'd2, 32'd0);
    rd(2'd0, 32'h0);
    rd(2'd3, 32'(BURST_PULSES));

    // DIV change during HIGH: the running phase keeps DIV=3, later phases use 1.
    wr(2'd1, 32'd3);
    wr(2'd3, 32'd0);
    hs = hi_lens.size();
    ls = lo_lens.size();
    wr(2'd0, 32'h1);
    wr(2'd1, 32'd1);
    rd(2'd0, 32'h31);                  // HIGH, BUSY, RUN
    repeat (12) @(negedge clk);
    wr(2'd0, 32'h0);
    repeat (12) @(negedge clk);
    check("divchg_hi_runs", 32'(hi_lens.size() - hs), 32'd4);
    check("divchg_lo_runs", 32'(lo_lens.size() - ls), 32'd4);
    if (hi_lens.size() > hs) check("divchg_first_hi", 32'(hi_lens[hs]), 32'd4);
    for (int i = hs + 1; i < hi_lens.size(); i++)
      check($sformatf("divchg_hi_len%0d", i - hs), 32'(hi_lens[i]), 32'd2);
    for (int i = ls + 1; i < lo_lens.size(); i++)
      check($sformatf("divchg_lo_len%0d", i - ls), 32'(lo_lens[i]), 32'd2);
    rd(2'd3, 32'd4);

    // Reset during a run: dbg_clk drops at once, and registers return to
    // their reset values.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dbg_clk) found = 1'b1;
    end
    check("reset_wait_high", {31'd0, found}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_async_clk", {31'd0, dbg_clk}, 32'd0);
    check("reset_async_rise", {31'd0, dbg_clk_rise}, 32'd0);
    check("reset_async_rdata", readdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_vecs(0, 3);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
